// File: rtl/mmu_sequencer_if.sv
// ============================================================================
// Module : mmu_sequencer_if
// Brief  : Command/status bundle between a pass requester and the systolic
//          array sequencer (start/abort in, array-edge and capture strobes out).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface mmu_sequencer_if #(
  parameter int N  = 2,
  parameter int KW = 4
);
  logic                 start;
  logic [KW-1:0]        k_len;
  logic                 abort;
  logic                 busy;
  logic                 done;
  logic                 clear;
  logic                 op_rd_en;
  logic [KW-1:0]        op_rd_addr;
  logic [1:0]           edge_ctrl;
  logic                 capture_en;
  logic [$clog2(N)-1:0] capture_row;

  modport master (
    output start, k_len, abort,
    input  busy, done, clear, op_rd_en, op_rd_addr, edge_ctrl, capture_en, capture_row
  );

  modport slave (
    input  start, k_len, abort,
    output busy, done, clear, op_rd_en, op_rd_addr, edge_ctrl, capture_en, capture_row
  );
endinterface

`default_nettype wire

// File: rtl/mmu_sequencer.sv
// ============================================================================
// Module : mmu_sequencer
// Brief  : Pass controller for an N x N systolic MAC array: clear, operand
//          feed, skew/latency drain and row-by-row result capture.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mmu_sequencer #(
  parameter int N      = 2,
  parameter int KW     = 4,
  parameter int PE_LAT = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  mmu_sequencer_if.slave   bus
);

  // Drain covers the operand skew across the array plus the PE pipeline.
  localparam int c_drain_len = 2 * (N - 1) + PE_LAT;
  localparam int c_drain_w   = $clog2(c_drain_len + 1);
  localparam int c_row_w     = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_FEED   = 3'd2,
    S_DRAIN  = 3'd3,
    S_OUTPUT = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                 r_state;
  logic [KW-1:0]          r_k_len;
  logic [KW-1:0]          r_addr;
  logic [c_drain_w-1:0]   r_drain_cnt;
  logic [c_row_w-1:0]     r_row;
  logic                   r_busy;
  logic                   r_done;
  logic                   r_clear;
  logic                   r_rd_en;
  logic [1:0]             r_edge;
  logic                   r_cap_en;

  logic w_feed_last;
  logic w_drain_last;
  logic w_row_last;

  assign w_feed_last  = (r_addr == r_k_len - KW'(1));
  assign w_drain_last = (r_drain_cnt == c_drain_w'(c_drain_len - 1));
  assign w_row_last   = (r_row == c_row_w'(N - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_addr      <= '0;
      r_drain_cnt <= '0;
      r_row       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clear     <= 1'b0;
      r_rd_en     <= 1'b0;
      r_edge      <= 2'b00;
      r_cap_en    <= 1'b0;
    end else begin
      // Single-cycle strobes fall back to idle unless a transition sets them.
      r_done   <= 1'b0;
      r_clear  <= 1'b0;
      r_edge   <= 2'b00;
      r_cap_en <= 1'b0;

      if (r_state != S_IDLE && bus.abort) begin
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_clear     <= 1'b1;
        r_rd_en     <= 1'b0;
        r_addr      <= '0;
        r_drain_cnt <= '0;
        r_row       <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (bus.start) begin
              if (bus.k_len != '0) begin
                r_state <= S_CLEAR;
                r_k_len <= bus.k_len;
                r_busy  <= 1'b1;
                r_clear <= 1'b1;
              end else begin
                r_done  <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            r_state <= S_FEED;
            r_rd_en <= 1'b1;
            r_addr  <= '0;
            r_edge  <= 2'b01;
          end
          S_FEED: begin
            if (w_feed_last) begin
              r_state     <= S_DRAIN;
              r_rd_en     <= 1'b0;
              r_addr      <= '0;
              r_drain_cnt <= '0;
            end else begin
              r_addr <= r_addr + KW'(1);
            end
          end
          S_DRAIN: begin
            if (w_drain_last) begin
              r_state  <= S_OUTPUT;
              r_cap_en <= 1'b1;
              r_row    <= '0;
            end else begin
              r_drain_cnt <= r_drain_cnt + c_drain_w'(1);
            end
          end
          S_OUTPUT: begin
            if (w_row_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_row   <= '0;
            end else begin
              r_row    <= r_row + c_row_w'(1);
              r_cap_en <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_rd_en <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.clear       = r_clear;
  assign bus.op_rd_en    = r_rd_en;
  assign bus.op_rd_addr  = r_addr;
  assign bus.edge_ctrl   = r_edge;
  assign bus.capture_en  = r_cap_en;
  assign bus.capture_row = r_row;

endmodule

`default_nettype wire

// File: tb/tb_mmu_sequencer.sv
// ============================================================================
// Module : tb_mmu_sequencer
// Brief  : Self-checking bench for mmu_sequencer; per-cycle output traces are
//          compared against a cycle-indexed model of a pass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mmu_sequencer;

  localparam int N      = 2;
  localparam int KW     = 4;
  localparam int PE_LAT = 3;
  localparam int C_D    = 2 * (N - 1) + PE_LAT;
  localparam int RW     = $clog2(N);
  localparam int OW     = 7 + KW + RW;

  typedef logic [OW-1:0] obs_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  mmu_sequencer_if #(.N(N), .KW(KW)) b ();

  mmu_sequencer #(.N(N), .KW(KW), .PE_LAT(PE_LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  always #5 clk = ~clk;

  // Expected outputs in cycle n (n=1 is the cycle right after the start edge).
  function automatic obs_t model(input int k, input int n, input int abort_at);
    logic       busy_e  = 1'b0;
    logic       done_e  = 1'b0;
    logic       clear_e = 1'b0;
    logic       rd_e    = 1'b0;
    logic       cap_e   = 1'b0;
    logic [1:0] edge_e  = 2'b00;
    int         addr_e  = 0;
    int         row_e   = 0;
    int         len;
    len = 2 + k + C_D + N;
    if (k == 0) begin
      done_e = (n == 1);
    end else if (abort_at != 0 && n > abort_at) begin
      clear_e = (n == abort_at + 1);
    end else if (n >= 1 && n <= len) begin
      busy_e = 1'b1;
      if (n == 1) begin
        clear_e = 1'b1;
      end else if (n <= 1 + k) begin
        rd_e   = 1'b1;
        addr_e = n - 2;
        edge_e = (n == 2) ? 2'b01 : 2'b00;
      end else if (n <= 1 + k + C_D) begin
        rd_e = 1'b0;
      end else if (n <= 1 + k + C_D + N) begin
        cap_e = 1'b1;
        row_e = n - 2 - k - C_D;
      end else begin
        done_e = 1'b1;
      end
    end
    return {busy_e, done_e, clear_e, rd_e, addr_e[KW-1:0], edge_e, cap_e, row_e[RW-1:0]};
  endfunction

  function automatic obs_t observe();
    return {b.busy, b.done, b.clear, b.op_rd_en, b.op_rd_addr, b.edge_ctrl,
            b.capture_en, b.capture_row};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pass: start is driven here and sampled by the next edge.
  task automatic do_pass(input string name, input int k, input bit noise,
                         input int abort_at, input bit abort_with_start);
    int   len;
    int   last;
    obs_t exp_v;
    obs_t act_v;
    len  = 2 + k + C_D + N;
    last = (k == 0) ? 3 : ((abort_at != 0) ? abort_at + 3 : len + 2);
    b.start = 1'b1;
    b.k_len = KW'(k);
    b.abort = abort_with_start;
    tick();
    b.start = 1'b0;
    b.abort = 1'b0;
    b.k_len = KW'($urandom);
    for (int n = 1; n <= last; n++) begin
      exp_v  = model(k, n, abort_at);
      act_v  = observe();
      n_checks++;
      if (act_v !== exp_v) begin
        n_fail++;
        $display("FAIL %s k=%0d cycle %0d: got %h expected %h", name, k, n, act_v, exp_v);
      end
      b.abort = (abort_at != 0 && n == abort_at);
      if (noise && k != 0 && ((abort_at == 0) ? (n <= len) : (n < abort_at))) begin
        b.start = 1'($urandom);
        b.k_len = KW'($urandom);
      end else begin
        b.start = 1'b0;
      end
      tick();
    end
    b.start = 1'b0;
    b.abort = 1'b0;
  endtask

  task automatic test_reset();
    rst     = 1'b0;
    b.start = 1'b0;
    b.abort = 1'b0;
    b.k_len = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (observe() !== '0) begin
        n_fail++;
        $display("FAIL reset_hold cycle %0d: got %h expected 0", i, observe());
      end
    end
    rst = 1'b1;
    tick();
    n_checks++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL reset_release: got %h expected 0", observe());
    end
  endtask

  task automatic test_normal();
    do_pass("normal_k4", 4, 1'b0, 0, 1'b0);
    do_pass("max_k", (1 << KW) - 1, 1'b0, 0, 1'b0);
  endtask

  task automatic test_zero_len();
    do_pass("zero_len", 0, 1'b0, 0, 1'b0);
  endtask

  task automatic test_back_to_back();
    do_pass("ignored_start", 5, 1'b1, 0, 1'b0);
    do_pass("abort_with_start", 3, 1'b0, 0, 1'b1);
  endtask

  task automatic test_abort();
    do_pass("abort_addr2", 6, 1'b0, 4, 1'b0);
    do_pass("abort_in_done", 2, 1'b0, 2 + 2 + C_D + N, 1'b0);
    b.abort = 1'b1;
    tick();
    tick();
    n_checks++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL abort_idle: got %h expected 0", observe());
    end
    b.abort = 1'b0;
  endtask

  task automatic test_async_reset();
    obs_t exp_v;
    b.start = 1'b1;
    b.k_len = KW'(3);
    tick();
    b.start = 1'b0;
    for (int n = 1; n < 1 + 3 + 2; n++) tick();
    exp_v = model(3, 1 + 3 + 2, 0);
    n_checks++;
    if (observe() !== exp_v) begin
      n_fail++;
      $display("FAIL drain_before_reset: got %h expected %h", observe(), exp_v);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (observe() !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected 0", observe());
    end
    tick();
    tick();
    rst = 1'b1;
    do_pass("after_reset", 4, 1'b0, 0, 1'b0);
  endtask

  task automatic test_random();
    int k;
    int ab;
    for (int i = 0; i < 8; i++) begin
      k  = $urandom_range(1, (1 << KW) - 1);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2 + k + C_D + N) : 0;
      do_pass("random", k, 1'b1, ab, 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_zero_len();
    test_back_to_back();
    test_abort();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
